// File: rtl/hann_window_scheduler_if.sv
// ---------------------------------------------------------------------------
// hann_window_scheduler_if
//
// Bundles the sample-side strobe, the hannifier go/done handshake and the
// scheduler's status outputs into one connection.
//
//   enable        level, gates dispatch
//   sample_we     one-cycle strobe, one sample written at wr_ptr
//   hann_done     one-cycle pulse, hannifier finished its window
//   go_out        one-cycle dispatch pulse to the hannifier
//   window_start  ring address of the dispatched window's first sample
//   busy          hannifier owns a window
//   wr_ptr        next ring write address
//   overrun_count windows dropped because the hannifier fell behind
//
// master: the surrounding system (input reader, hannifier, control)
// slave : the scheduler itself
// ---------------------------------------------------------------------------
interface hann_window_scheduler_if #(
  parameter int AW = 13
);

  logic          enable;
  logic          sample_we;
  logic          hann_done;
  logic          go_out;
  logic [AW-1:0] window_start;
  logic          busy;
  logic [AW-1:0] wr_ptr;
  logic [7:0]    overrun_count;

  modport master (
    output enable,
    output sample_we,
    output hann_done,
    input  go_out,
    input  window_start,
    input  busy,
    input  wr_ptr,
    input  overrun_count
  );

  modport slave (
    input  enable,
    input  sample_we,
    input  hann_done,
    output go_out,
    output window_start,
    output busy,
    output wr_ptr,
    output overrun_count
  );

endinterface

// File: rtl/hann_window_scheduler.sv
// ---------------------------------------------------------------------------
// hann_window_scheduler
//
// Dispatch controller for the Hann windowing stage. Mirrors the input
// reader's ring write pointer, detects when a full hop of new samples has
// landed on top of a complete window, and pulses the hannifier with the
// start address of the newest complete window. While the hannifier is busy
// at most one dispatch is held pending; any older pending window that gets
// replaced is counted as an overrun.
//
// Ports:
//   clk      system clock, rising edge
//   reset_n  asynchronous active-low reset
//   bus      hann_window_scheduler_if.slave (enable, sample_we, hann_done in;
//            go_out, window_start, busy, wr_ptr, overrun_count out)
//
// Parameters:
//   WINDOW      samples per analysis window
//   HOP         new samples between windows (WINDOW must be a multiple)
//   RING_DEPTH  ring depth, WINDOW + HOP
//   AW          ring address width
//
// Dispatcher states:
//   state        | meaning
//   -------------+-------------------------------------------------------
//   S_IDLE       | hannifier free, nothing pending
//   S_BUSY       | hannifier owns a window, nothing pending
//   S_BUSY_PEND  | hannifier owns a window, one newer window held in
//                | pend_start
// ---------------------------------------------------------------------------
module hann_window_scheduler #(
  parameter int WINDOW     = 4096,
  parameter int HOP        = 1024,
  parameter int RING_DEPTH = 5120,
  parameter int AW         = 13
) (
  input  logic                      clk,
  input  logic                      reset_n,
  hann_window_scheduler_if.slave    bus
);

  localparam int HW = (HOP > 1) ? $clog2(HOP) : 1;
  localparam int FW = (WINDOW > 1) ? $clog2(WINDOW) : 1;

  localparam logic [HW-1:0] HOP_RELOAD  = HW'(HOP - 1);
  localparam logic [FW-1:0] FILL_RELOAD = FW'(WINDOW - 1);
  localparam logic [AW-1:0] RING_LAST   = AW'(RING_DEPTH - 1);
  localparam logic [AW:0]   HOP_EXT     = (AW+1)'(HOP);
  localparam logic [AW:0]   RING_EXT    = (AW+1)'(RING_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_BUSY      = 2'd1,
    S_BUSY_PEND = 2'd2
  } state_t;

  state_t        state;
  state_t        state_nxt;

  logic [HW-1:0] hop_left;
  logic [FW-1:0] fill_left;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] wr_ptr_next;
  logic [AW:0]   start_sum;
  logic [AW-1:0] boundary_start;
  logic [AW-1:0] pend_start;
  logic [AW-1:0] window_start;
  logic [AW-1:0] start_sel;
  logic [7:0]    overrun_count;
  logic          go_out;

  logic          hop_tc;
  logic          fill_tc;
  logic          boundary;
  logic          done_valid;
  logic          pend;
  logic          go_nxt;
  logic          pend_load;
  logic          overrun_inc;

  // -------------------------------------------------------------------------
  // Ring write pointer and boundary address
  // -------------------------------------------------------------------------
  assign wr_ptr_next = (wr_ptr == RING_LAST) ? '0 : wr_ptr + 1'b1;

  // Newest window starts HOP past the post-increment write pointer, which is
  // the same slot as wr_ptr_next - WINDOW modulo the ring. A single
  // compare-and-subtract folds it back into range.
  assign start_sum      = {1'b0, wr_ptr_next} + HOP_EXT;
  assign boundary_start = (start_sum >= RING_EXT) ? AW'(start_sum - RING_EXT)
                                                  : start_sum[AW-1:0];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
    end else if (bus.sample_we) begin
      wr_ptr <= wr_ptr_next;
    end
  end

  // -------------------------------------------------------------------------
  // Hop and fill timers (down-counters, terminal count at zero).
  // hop_left hits zero on the last sample of each hop; fill_left hits zero
  // once the current sample completes the first full window and then stays.
  // -------------------------------------------------------------------------
  assign hop_tc  = (hop_left == '0);
  assign fill_tc = (fill_left == '0);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hop_left  <= HOP_RELOAD;
      fill_left <= FILL_RELOAD;
    end else if (!bus.enable) begin
      hop_left  <= HOP_RELOAD;
      fill_left <= FILL_RELOAD;
    end else if (bus.sample_we) begin
      hop_left <= hop_tc ? HOP_RELOAD : hop_left - 1'b1;
      if (!fill_tc) begin
        fill_left <= fill_left - 1'b1;
      end
    end
  end

  assign boundary   = bus.enable && bus.sample_we && hop_tc && fill_tc;
  assign done_valid = bus.hann_done && (state != S_IDLE);
  assign pend       = (state == S_BUSY_PEND);

  // -------------------------------------------------------------------------
  // Dispatcher: state register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // -------------------------------------------------------------------------
  // Dispatcher: next state
  // -------------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    if (!bus.enable) begin
      // Pending work is discarded; an in-flight window still completes.
      if (done_valid || (state == S_IDLE)) begin
        state_nxt = S_IDLE;
      end else begin
        state_nxt = S_BUSY;
      end
    end else begin
      case (state)
        S_IDLE: begin
          if (boundary) begin
            state_nxt = S_BUSY;
          end
        end
        S_BUSY: begin
          if (boundary) begin
            state_nxt = done_valid ? S_BUSY : S_BUSY_PEND;
          end else if (done_valid) begin
            state_nxt = S_IDLE;
          end
        end
        S_BUSY_PEND: begin
          // Done with or without a boundary leads to a redispatch.
          if (done_valid) begin
            state_nxt = S_BUSY;
          end
        end
        default: begin
          state_nxt = S_IDLE;
        end
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Dispatcher: output decisions
  // -------------------------------------------------------------------------
  always_comb begin
    go_nxt      = 1'b0;
    start_sel   = pend_start;
    pend_load   = 1'b0;
    overrun_inc = 1'b0;
    if (bus.enable) begin
      if (boundary && ((state == S_IDLE) || done_valid)) begin
        // Newest window wins; a pending one it displaces is lost.
        go_nxt      = 1'b1;
        start_sel   = boundary_start;
        overrun_inc = pend;
      end else if (boundary) begin
        pend_load   = 1'b1;
        overrun_inc = pend;
      end else if (done_valid && pend) begin
        go_nxt    = 1'b1;
        start_sel = pend_start;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      go_out        <= 1'b0;
      window_start  <= '0;
      pend_start    <= '0;
      overrun_count <= '0;
    end else begin
      go_out <= go_nxt;
      if (go_nxt) begin
        window_start <= start_sel;
      end
      if (pend_load) begin
        pend_start <= boundary_start;
      end
      if (overrun_inc && (overrun_count != 8'hFF)) begin
        overrun_count <= overrun_count + 8'd1;
      end
    end
  end

  assign bus.go_out        = go_out;
  assign bus.window_start  = window_start;
  assign bus.busy          = (state != S_IDLE);
  assign bus.wr_ptr        = wr_ptr;
  assign bus.overrun_count = overrun_count;

endmodule

// File: tb/tb_hann_window_scheduler.sv
// ---------------------------------------------------------------------------
// tb_hann_window_scheduler
//
// Runs the scheduler with a scaled-down geometry (WINDOW=64, HOP=16,
// RING_DEPTH=80) so saturation and wrap cases stay short. The reference
// model counts samples since enable and derives boundaries and start
// addresses with plain modulo arithmetic.
// ---------------------------------------------------------------------------
module tb_hann_window_scheduler;

  localparam int WINDOW = 64;
  localparam int HOP    = 16;
  localparam int RING   = 80;
  localparam int AW     = 7;

  logic clk = 1'b0;
  logic reset_n;

  always #5 clk = ~clk;

  hann_window_scheduler_if #(.AW(AW)) bus ();

  hann_window_scheduler #(
    .WINDOW     (WINDOW),
    .HOP        (HOP),
    .RING_DEPTH (RING),
    .AW         (AW)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int n_chk  = 0;
  int n_pass = 0;

  // reference model state
  int m_wr, m_n, m_pst, m_ws, m_ovr;
  bit m_busy, m_pend, m_go;

  // observation counters kept while cycling
  int dut_go, go_skew, busy_low;

  function automatic void m_reset();
    m_wr = 0; m_n = 0; m_pst = 0; m_ws = 0; m_ovr = 0;
    m_busy = 0; m_pend = 0; m_go = 0;
  endfunction

  function automatic void m_step(input bit we, input bit done, input bit en);
    bit bnd;
    bit d;
    int st;
    bnd = 0;
    st  = 0;
    d   = done && m_busy;
    m_go = 0;
    if (we) begin
      m_wr = (m_wr + 1) % RING;
      if (en) begin
        m_n++;
        if (m_n >= WINDOW && (m_n % HOP) == 0) begin
          bnd = 1;
          st  = (m_wr + RING - WINDOW) % RING;
        end
      end
    end
    if (!en) begin
      m_n = 0;
      m_pend = 0;
      if (d) m_busy = 0;
    end else if (bnd && (!m_busy || d)) begin
      m_go = 1; m_ws = st;
      if (m_pend && m_ovr < 255) m_ovr++;
      m_pend = 0; m_busy = 1;
    end else if (bnd) begin
      if (m_pend && m_ovr < 255) m_ovr++;
      m_pend = 1; m_pst = st;
    end else if (d && m_pend) begin
      m_go = 1; m_ws = m_pst; m_pend = 0;
    end else if (d) begin
      m_busy = 0;
    end
  endfunction

  task automatic cyc(input bit we, input bit done);
    @(negedge clk);
    bus.sample_we = we;
    bus.hann_done = done;
    m_step(we, done, bus.enable);
    @(posedge clk);
    #1;
    bus.sample_we = 1'b0;
    bus.hann_done = 1'b0;
    if (bus.go_out === 1'b1) dut_go++;
    if (bus.go_out !== m_go) go_skew++;
    if (bus.busy !== 1'b1) busy_low++;
  endtask

  task automatic feed(input int n, input int gap_max);
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(0, gap_max)) cyc(1'b0, 1'b0);
      cyc(1'b1, 1'b0);
    end
  endtask

  task automatic clear_obs();
    dut_go = 0; go_skew = 0; busy_low = 0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    bus.enable = 1'b1;
    bus.sample_we = 1'b0;
    bus.hann_done = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      bus.sample_we = 1'($urandom_range(0, 1));
      bus.hann_done = 1'($urandom_range(0, 1));
      @(posedge clk);
      #1;
      n_chk++;
      if (bus.go_out !== 1'b0 || bus.window_start !== '0 || bus.busy !== 1'b0 ||
          bus.wr_ptr !== '0 || bus.overrun_count !== 8'd0)
        $display("FAIL reset_hold[%0d]: go=%0b ws=%0d busy=%0b wr=%0d ovr=%0d, required all 0",
                 i, bus.go_out, bus.window_start, bus.busy, bus.wr_ptr, bus.overrun_count);
      else n_pass++;
    end
    @(negedge clk);
    bus.sample_we = 1'b0;
    bus.hann_done = 1'b0;
    reset_n = 1'b1;
    m_reset();
  endtask

  task automatic test_prime();
    clear_obs();
    feed(WINDOW - 1, 2);
    n_chk++;
    if (dut_go !== 0) $display("FAIL prime_early_go: got %0d pulses, required 0", dut_go);
    else n_pass++;
    cyc(1'b1, 1'b0);
    n_chk++;
    if (bus.go_out !== 1'b1 || bus.window_start !== AW'(0) || bus.busy !== 1'b1 ||
        bus.wr_ptr !== AW'(WINDOW))
      $display("FAIL prime_go: go=%0b ws=%0d busy=%0b wr=%0d, required go=1 ws=0 busy=1 wr=%0d",
               bus.go_out, bus.window_start, bus.busy, bus.wr_ptr, WINDOW);
    else n_pass++;
    cyc(1'b0, 1'b0);
    n_chk++;
    if (bus.go_out !== 1'b0 || bus.busy !== 1'b1)
      $display("FAIL prime_pulse_width: go=%0b busy=%0b, required go=0 busy=1", bus.go_out, bus.busy);
    else n_pass++;
  endtask

  task automatic test_hops();
    int exp_ws [6] = '{16, 32, 48, 64, 0, 16};
    cyc(1'b0, 1'b1);
    n_chk++;
    if (bus.busy !== 1'b0) $display("FAIL hops_done_clears_busy: busy=%0b, required 0", bus.busy);
    else n_pass++;
    for (int h = 0; h < 6; h++) begin
      clear_obs();
      feed(HOP - 1, 2);
      cyc(1'b1, 1'b0);
      n_chk++;
      if (bus.go_out !== 1'b1 || bus.window_start !== AW'(exp_ws[h]) || dut_go !== 1)
        $display("FAIL hop_start[%0d]: go=%0b ws=%0d pulses=%0d, required go=1 ws=%0d pulses=1",
                 h, bus.go_out, bus.window_start, dut_go, exp_ws[h]);
      else n_pass++;
      cyc(1'b0, 1'b1);
    end
    n_chk++;
    if (bus.wr_ptr !== AW'((WINDOW + 6 * HOP) % RING) || bus.overrun_count !== 8'd0 || bus.busy !== 1'b0)
      $display("FAIL hops_end: wr=%0d ovr=%0d busy=%0b, required wr=%0d ovr=0 busy=0",
               bus.wr_ptr, bus.overrun_count, bus.busy, (WINDOW + 6 * HOP) % RING);
    else n_pass++;
  endtask

  task automatic test_pend();
    int exp_start;
    feed(HOP, 2);
    clear_obs();
    feed(HOP, 2);
    exp_start = (m_wr + HOP) % RING;
    repeat (3) cyc(1'b0, 1'b0);
    n_chk++;
    if (dut_go !== 0) $display("FAIL pend_no_go_while_busy: got %0d pulses, required 0", dut_go);
    else n_pass++;
    cyc(1'b0, 1'b1);
    n_chk++;
    if (bus.go_out !== 1'b1 || bus.window_start !== AW'(exp_start) || busy_low !== 0 ||
        bus.overrun_count !== 8'd0)
      $display("FAIL pend_redispatch: go=%0b ws=%0d busy_low=%0d ovr=%0d, required go=1 ws=%0d busy_low=0 ovr=0",
               bus.go_out, bus.window_start, busy_low, bus.overrun_count, exp_start);
    else n_pass++;
    cyc(1'b0, 1'b1);
    n_chk++;
    if (bus.busy !== 1'b0 || go_skew !== 0)
      $display("FAIL pend_release: busy=%0b go_skew=%0d, required busy=0 go_skew=0", bus.busy, go_skew);
    else n_pass++;
  endtask

  task automatic test_overrun();
    int exp_start;
    feed(HOP, 2);
    clear_obs();
    feed(HOP, 2);
    feed(HOP, 2);
    exp_start = (m_wr + HOP) % RING;
    cyc(1'b0, 1'b1);
    n_chk++;
    if (bus.go_out !== 1'b1 || bus.window_start !== AW'(exp_start) || bus.overrun_count !== 8'd1)
      $display("FAIL overrun_newest: go=%0b ws=%0d ovr=%0d, required go=1 ws=%0d ovr=1",
               bus.go_out, bus.window_start, bus.overrun_count, exp_start);
    else n_pass++;
    clear_obs();
    feed(300 * HOP, 0);
    n_chk++;
    if (bus.overrun_count !== 8'd255 || dut_go !== 0 || busy_low !== 0)
      $display("FAIL overrun_saturate: ovr=%0d pulses=%0d busy_low=%0d, required ovr=255 pulses=0 busy_low=0",
               bus.overrun_count, dut_go, busy_low);
    else n_pass++;
    cyc(1'b0, 1'b1);
    cyc(1'b0, 1'b1);
    n_chk++;
    if (bus.busy !== 1'b0 || bus.overrun_count !== 8'd255)
      $display("FAIL overrun_drain: busy=%0b ovr=%0d, required busy=0 ovr=255", bus.busy, bus.overrun_count);
    else n_pass++;
  endtask

  task automatic test_done_same_cycle();
    int exp_start;
    feed(HOP, 2);
    clear_obs();
    feed(HOP - 1, 2);
    exp_start = ((m_wr + 1) % RING + HOP) % RING;
    cyc(1'b1, 1'b1);
    n_chk++;
    if (bus.go_out !== 1'b1 || bus.window_start !== AW'(exp_start) || busy_low !== 0 ||
        bus.overrun_count !== 8'd255)
      $display("FAIL same_cycle: go=%0b ws=%0d busy_low=%0d ovr=%0d, required go=1 ws=%0d busy_low=0 ovr=255",
               bus.go_out, bus.window_start, busy_low, bus.overrun_count, exp_start);
    else n_pass++;
    cyc(1'b0, 1'b1);
  endtask

  task automatic test_enable();
    int exp_wr;
    feed(HOP, 2);
    feed(7, 2);
    bus.enable = 1'b0;
    clear_obs();
    feed(10, 1);
    cyc(1'b0, 1'b1);
    n_chk++;
    if (bus.busy !== 1'b0 || dut_go !== 0)
      $display("FAIL enable_low_done: busy=%0b pulses=%0d, required busy=0 pulses=0", bus.busy, dut_go);
    else n_pass++;
    bus.enable = 1'b1;
    exp_wr = (m_wr + WINDOW) % RING;
    feed(WINDOW - 1, 2);
    n_chk++;
    if (dut_go !== 0) $display("FAIL reenable_early_go: got %0d pulses, required 0", dut_go);
    else n_pass++;
    cyc(1'b1, 1'b0);
    n_chk++;
    if (bus.go_out !== 1'b1 || bus.wr_ptr !== AW'(exp_wr) ||
        bus.window_start !== AW'((exp_wr + HOP) % RING))
      $display("FAIL reenable_go: go=%0b wr=%0d ws=%0d, required go=1 wr=%0d ws=%0d",
               bus.go_out, bus.wr_ptr, bus.window_start, exp_wr, (exp_wr + HOP) % RING);
    else n_pass++;
  endtask

  task automatic test_reset_mid_busy();
    @(negedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    n_chk++;
    if (bus.go_out !== 1'b0 || bus.window_start !== '0 || bus.busy !== 1'b0 ||
        bus.wr_ptr !== '0 || bus.overrun_count !== 8'd0)
      $display("FAIL reset_async: go=%0b ws=%0d busy=%0b wr=%0d ovr=%0d, required all 0",
               bus.go_out, bus.window_start, bus.busy, bus.wr_ptr, bus.overrun_count);
    else n_pass++;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    m_reset();
    clear_obs();
    cyc(1'b0, 1'b1);
    feed(WINDOW - 1, 2);
    n_chk++;
    if (dut_go !== 0 || bus.busy !== 1'b0)
      $display("FAIL reset_no_go: pulses=%0d busy=%0b, required pulses=0 busy=0", dut_go, bus.busy);
    else n_pass++;
    cyc(1'b1, 1'b0);
    n_chk++;
    if (bus.go_out !== 1'b1 || bus.window_start !== AW'(0))
      $display("FAIL reset_reprime: go=%0b ws=%0d, required go=1 ws=0", bus.go_out, bus.window_start);
    else n_pass++;
  endtask

  task automatic test_random();
    int errs;
    errs = 0;
    @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    bus.enable = 1'b1;
    m_reset();
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 199) == 0) bus.enable = ~bus.enable;
      cyc(1'($urandom_range(0, 9) < 7), 1'($urandom_range(0, 9) == 0));
      n_chk++;
      if (bus.go_out !== m_go || bus.window_start !== AW'(m_ws) || bus.busy !== m_busy ||
          bus.wr_ptr !== AW'(m_wr) || bus.overrun_count !== 8'(m_ovr)) begin
        errs++;
        if (errs <= 10)
          $display("FAIL random[%0d]: go=%0b ws=%0d busy=%0b wr=%0d ovr=%0d, required go=%0b ws=%0d busy=%0b wr=%0d ovr=%0d",
                   i, bus.go_out, bus.window_start, bus.busy, bus.wr_ptr, bus.overrun_count,
                   m_go, m_ws, m_busy, m_wr, m_ovr);
      end else n_pass++;
    end
  endtask

  initial begin
    bus.enable    = 1'b1;
    bus.sample_we = 1'b0;
    bus.hann_done = 1'b0;
    reset_n       = 1'b0;
    m_reset();
    clear_obs();
    test_reset();
    test_prime();
    test_hops();
    test_pend();
    test_overrun();
    test_done_same_cycle();
    test_enable();
    test_reset_mid_busy();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
